// File: rtl/rice_core_muldiv.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply, restoring divide, 1 bit/cycle.
// Latency: XLEN+2 cycles from accept to result valid; divide-by-zero/overflow fast path is 1 cycle.
// Backpressure: o_ready only in IDLE; result held in DONE until i_result_ready; i_flush aborts anything.
module rice_core_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_command,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_result_valid,
  input  logic            i_result_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      cmd;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] opnd;   // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0] hi;     // product high half / partial remainder
  logic [XLEN-1:0] lo;     // multiplier being consumed / dividend shifting into quotient

  logic            is_div, sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  // Request decode, one iteration step, and final sign fix-up / result select
  always_comb begin
    is_div   = i_command[2];
    sgn_a    = (i_command == 3'b001) || (i_command == 3'b010) ||
               (i_command == 3'b100) || (i_command == 3'b110);
    sgn_b    = (i_command == 3'b001) || (i_command == 3'b100) || (i_command == 3'b110);
    in_neg_a = sgn_a & i_rs1[XLEN-1];
    in_neg_b = sgn_b & i_rs2[XLEN-1];
    abs_a    = in_neg_a ? -i_rs1 : i_rs1;
    abs_b    = in_neg_b ? -i_rs2 : i_rs2;
    div_zero = is_div && (i_rs2 == '0);
    // Only signed DIV/REM (funct3 bit0 clear) can overflow
    div_ovf  = is_div && !i_command[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = i_command[1] ? i_rs1 : '1;
    else          fast_res = i_command[1] ? '0 : i_rs1;

    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];

    prod_fix = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    quo_fix  = (neg_a ^ neg_b) ? -lo : lo;
    rem_fix  = neg_a ? -hi : hi;
    case (cmd)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      o_ready        <= 1'b1;
      o_result_valid <= 1'b0;
      o_result       <= '0;
      count          <= '0;
      cmd            <= '0;
      neg_a          <= 1'b0;
      neg_b          <= 1'b0;
      opnd           <= '0;
      hi             <= '0;
      lo             <= '0;
    end else if (i_flush) begin
      state          <= IDLE;
      o_ready        <= 1'b1;
      o_result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            cmd     <= i_command;
            neg_a   <= in_neg_a;
            neg_b   <= in_neg_b;
            opnd    <= is_div ? abs_b : abs_a;
            lo      <= is_div ? abs_a : abs_b;
            hi      <= '0;
            count   <= CW'(XLEN-1);
            o_ready <= 1'b0;
            if (fast) begin
              state          <= DONE;
              o_result       <= fast_res;
              o_result_valid <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cmd[2]) begin
            hi <= div_rem;
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          count <= count - CW'(1);
          if (count == '0) state <= FIXUP;
        end
        FIXUP: begin
          o_result       <= fix_res;
          o_result_valid <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (i_result_ready) begin
            state          <= IDLE;
            o_result_valid <= 1'b0;
            o_ready        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
